// File: rtl/rv_pkg.sv
// RV32I decode constants, instruction-format enum and the decoded ID/EX record.
// Shared by the decode stage and its immediate generator.
package rv_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  localparam logic [2:0] FN3_ADD = 3'b000;
  localparam logic [2:0] FN3_SLL = 3'b001;
  localparam logic [2:0] FN3_SW  = 3'b010;
  localparam logic [2:0] FN3_SLT = 3'b010;
  localparam logic [2:0] FN3_SLTU = 3'b011;
  localparam logic [2:0] FN3_SRX = 3'b101;

  localparam logic [6:0] FN7_BASE   = 7'b0000000;
  localparam logic [6:0] FN7_ALT    = 7'b0100000;
  localparam logic [6:0] FN7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    FMT_NONE,
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J
  } fmt_e;

  // Immediate and PC are XLEN wide, a module parameter, so they are held
  // beside this record rather than inside it.
  typedef struct packed {
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [2:0] fn3;
    logic [6:0] fn7;
    logic       rd_we;
    logic       is_load;
    logic       is_store;
    logic       is_branch;
    logic       is_jump;
    logic       illegal;
  } decoded_t;

  function automatic fmt_e opcode_fmt(input logic [6:0] opc);
    fmt_e f;
    case (opc)
      OP_LUI, OP_AUIPC:         f = FMT_U;
      OP_JAL:                   f = FMT_J;
      OP_JALR, OP_LOAD, OP_IMM: f = FMT_I;
      OP_BRANCH:                f = FMT_B;
      OP_STORE:                 f = FMT_S;
      OP_OP:                    f = FMT_R;
      default:                  f = FMT_NONE;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side handshake plus decoded output bus of the decode stage.
// Both sides use valid/ready: a transfer happens on a rising edge where valid and
// ready are both high; valid never waits on ready, and payload holds while valid & !ready.
interface decode_stage_if #(
  parameter int XLEN = 32
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [6:0]      out_opcode;
  logic [4:0]      out_rd;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [2:0]      out_fn3;
  logic [6:0]      out_fn7;
  logic [XLEN-1:0] out_imm;
  logic [XLEN-1:0] out_pc;
  logic            out_rd_we;
  logic            out_is_load;
  logic            out_is_store;
  logic            out_is_branch;
  logic            out_is_jump;
  logic            out_illegal;

  modport master (
    output flush, in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_opcode, out_rd, out_rs1, out_rs2, out_fn3,
           out_fn7, out_imm, out_pc, out_rd_we, out_is_load, out_is_store,
           out_is_branch, out_is_jump, out_illegal
  );

  modport slave (
    input  flush, in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_opcode, out_rd, out_rs1, out_rs2, out_fn3,
           out_fn7, out_imm, out_pc, out_rd_we, out_is_load, out_is_store,
           out_is_branch, out_is_jump, out_illegal
  );
endinterface

// File: rtl/decode_stage_imm_gen.sv
// Combinational immediate extraction for the RV32I I/S/B/U/J formats,
// sign-extended to the datapath width; R-type and unknown formats give zero.
module imm_gen
  import rv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:7]     inst,
  input  fmt_e            fmt,
  output logic [XLEN-1:0] imm
);

  logic [31:0] imm32;

  always_comb begin
    imm32 = '0;
    case (fmt)
      FMT_I: imm32 = {{20{inst[31]}}, inst[31:20]};
      FMT_S: imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      FMT_B: imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      FMT_U: imm32 = {inst[31:12], 12'b0};
      FMT_J: imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: field extraction, classification and legality checking
// into a registered ID/EX slot with valid/ready flow control, flush and load-use stall.
module decode_stage
  import rv_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter bit EN_M      = 1'b0,
  parameter bit HAZARD_EN = 1'b1
) (
  input logic           clk,
  input logic           rst,
  decode_stage_if.slave bus
);

  logic [31:0]     inst;
  logic [6:0]      opc;
  logic [6:0]      fn7_raw;
  logic [2:0]      fn3;
  logic            has_rd;
  logic            has_rs1;
  logic            has_rs2;
  logic            has_fn3;
  logic            has_fn7;
  logic            known;
  logic            bad;
  logic            illegal;
  fmt_e            fmt;
  decoded_t        dec_d;
  decoded_t        dec_q;
  logic [XLEN-1:0] imm_d;
  logic [XLEN-1:0] imm_q;
  logic [XLEN-1:0] pc_q;
  logic            out_valid_q;
  logic            hazard;
  logic            in_ready;
  logic            accept;

  assign inst    = bus.in_inst;
  assign opc     = inst[6:0];
  assign fn3     = inst[14:12];
  assign fn7_raw = inst[31:25];

  // Which fields the opcode carries, and whether its sub-encoding is reserved.
  always_comb begin
    has_rd  = 1'b0;
    has_rs1 = 1'b0;
    has_rs2 = 1'b0;
    has_fn3 = 1'b0;
    has_fn7 = 1'b0;
    known   = 1'b1;
    bad     = 1'b0;
    case (opc)
      OP_LUI, OP_AUIPC, OP_JAL: has_rd = 1'b1;
      OP_JALR: begin
        has_rd  = 1'b1;
        has_rs1 = 1'b1;
        has_fn3 = 1'b1;
        bad     = (fn3 != FN3_ADD);
      end
      OP_BRANCH: begin
        has_rs1 = 1'b1;
        has_rs2 = 1'b1;
        has_fn3 = 1'b1;
        bad     = (fn3 == FN3_SLT) || (fn3 == FN3_SLTU);
      end
      OP_LOAD: begin
        has_rd  = 1'b1;
        has_rs1 = 1'b1;
        has_fn3 = 1'b1;
        bad     = (fn3 == 3'b011) || (fn3 == 3'b110) || (fn3 == 3'b111);
      end
      OP_STORE: begin
        has_rs1 = 1'b1;
        has_rs2 = 1'b1;
        has_fn3 = 1'b1;
        bad     = (fn3 > FN3_SW);
      end
      OP_IMM: begin
        has_rd  = 1'b1;
        has_rs1 = 1'b1;
        has_fn3 = 1'b1;
        has_fn7 = (fn3 == FN3_SLL) || (fn3 == FN3_SRX);
        if (fn3 == FN3_SLL) begin
          bad = (fn7_raw != FN7_BASE);
        end else if (fn3 == FN3_SRX) begin
          bad = (fn7_raw != FN7_BASE) && (fn7_raw != FN7_ALT);
        end
      end
      OP_OP: begin
        has_rd  = 1'b1;
        has_rs1 = 1'b1;
        has_rs2 = 1'b1;
        has_fn3 = 1'b1;
        has_fn7 = 1'b1;
        case (fn7_raw)
          FN7_BASE:   bad = 1'b0;
          FN7_ALT:    bad = (fn3 != FN3_ADD) && (fn3 != FN3_SRX);
          FN7_MULDIV: bad = !EN_M;
          default:    bad = 1'b1;
        endcase
      end
      default: known = 1'b0;
    endcase
  end

  assign illegal = !known || bad || (inst[1:0] != 2'b11);
  assign fmt     = opcode_fmt(opc);

  always_comb begin
    dec_d           = '0;
    dec_d.opcode    = opc;
    dec_d.rd        = has_rd  ? inst[11:7]  : 5'd0;
    dec_d.rs1       = has_rs1 ? inst[19:15] : 5'd0;
    dec_d.rs2       = has_rs2 ? inst[24:20] : 5'd0;
    dec_d.fn3       = has_fn3 ? fn3         : 3'd0;
    dec_d.fn7       = has_fn7 ? fn7_raw     : 7'd0;
    dec_d.rd_we     = has_rd && (inst[11:7] != 5'd0) && !illegal;
    dec_d.is_load   = (opc == OP_LOAD)   && !illegal;
    dec_d.is_store  = (opc == OP_STORE)  && !illegal;
    dec_d.is_branch = (opc == OP_BRANCH) && !illegal;
    dec_d.is_jump   = ((opc == OP_JAL) || (opc == OP_JALR)) && !illegal;
    dec_d.illegal   = illegal;
  end

  imm_gen #(
    .XLEN(XLEN)
  ) u_imm_gen (
    .inst(inst[31:7]),
    .fmt (fmt),
    .imm (imm_d)
  );

  // Only a legal load with a real destination can stall; unused source fields
  // are already zero, so they never match a non-zero rd.
  assign hazard = HAZARD_EN && out_valid_q && dec_q.is_load && (dec_q.rd != 5'd0) &&
                  ((dec_d.rs1 == dec_q.rd) || (dec_d.rs2 == dec_q.rd));

  assign in_ready = (!out_valid_q || bus.out_ready) && !hazard && !bus.flush;
  assign accept   = bus.in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      dec_q       <= '0;
      imm_q       <= '0;
      pc_q        <= '0;
    end else if (bus.flush) begin
      out_valid_q <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      dec_q       <= dec_d;
      imm_q       <= imm_d;
      pc_q        <= bus.in_pc;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready      = in_ready;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_opcode    = dec_q.opcode;
  assign bus.out_rd        = dec_q.rd;
  assign bus.out_rs1       = dec_q.rs1;
  assign bus.out_rs2       = dec_q.rs2;
  assign bus.out_fn3       = dec_q.fn3;
  assign bus.out_fn7       = dec_q.fn7;
  assign bus.out_imm       = imm_q;
  assign bus.out_pc        = pc_q;
  assign bus.out_rd_we     = dec_q.rd_we;
  assign bus.out_is_load   = dec_q.is_load;
  assign bus.out_is_store  = dec_q.is_store;
  assign bus.out_is_branch = dec_q.is_branch;
  assign bus.out_is_jump   = dec_q.is_jump;
  assign bus.out_illegal   = dec_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: default build (no M, hazard stall) and an
// M-enabled, no-stall build, with an expected-output queue per instance.
`timescale 1ns/1ps
module tb_decode_stage;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  fn3;
    logic [6:0]  fn7;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [5:0]  flg;   // {rd_we, is_load, is_store, is_branch, is_jump, illegal}
  } exp_t;

  localparam int W = $bits(exp_t);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];

  always #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  decode_stage_if #(.XLEN(32)) bus0 ();
  decode_stage_if #(.XLEN(32)) bus1 ();

  decode_stage #(.XLEN(32), .EN_M(1'b0), .HAZARD_EN(1'b1)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0.slave)
  );
  decode_stage #(.XLEN(32), .EN_M(1'b1), .HAZARD_EN(1'b0)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave)
  );

  function automatic exp_t mk(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [2:0] fn3, input logic [6:0] fn7,
                              input logic [31:0] imm, input logic [31:0] pc, input logic [5:0] flg);
    exp_t e;
    e.opcode = op; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2; e.fn3 = fn3;
    e.fn7 = fn7; e.imm = imm; e.pc = pc; e.flg = flg;
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cmp_out(input string name, input exp_t act, input exp_t exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got op=%h rd=%0d rs1=%0d rs2=%0d fn3=%0d fn7=%h imm=%h pc=%h flg=%b expected op=%h rd=%0d rs1=%0d rs2=%0d fn3=%0d fn7=%h imm=%h pc=%h flg=%b",
               name, act.opcode, act.rd, act.rs1, act.rs2, act.fn3, act.fn7, act.imm, act.pc, act.flg,
               exp.opcode, exp.rd, exp.rs1, exp.rs2, exp.fn3, exp.fn7, exp.imm, exp.pc, exp.flg);
    end
  endtask

  // ---------------- monitors ----------------
  initial forever begin
    @(negedge clk);
    if (!rst && bus0.out_valid && bus0.out_ready && !bus0.flush) begin
      if (exp_q0.size() == 0) begin
        checks = checks + 1;
        errors = errors + 1;
        $display("FAIL out0_unexpected: output pc=%h with nothing expected", bus0.out_pc);
      end else begin
        cmp_out("out0", mk(bus0.out_opcode, bus0.out_rd, bus0.out_rs1, bus0.out_rs2, bus0.out_fn3,
                           bus0.out_fn7, bus0.out_imm, bus0.out_pc,
                           {bus0.out_rd_we, bus0.out_is_load, bus0.out_is_store,
                            bus0.out_is_branch, bus0.out_is_jump, bus0.out_illegal}),
                exp_t'(exp_q0.pop_front()));
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst && bus1.out_valid && bus1.out_ready && !bus1.flush) begin
      if (exp_q1.size() == 0) begin
        checks = checks + 1;
        errors = errors + 1;
        $display("FAIL out1_unexpected: output pc=%h with nothing expected", bus1.out_pc);
      end else begin
        cmp_out("out1", mk(bus1.out_opcode, bus1.out_rd, bus1.out_rs1, bus1.out_rs2, bus1.out_fn3,
                           bus1.out_fn7, bus1.out_imm, bus1.out_pc,
                           {bus1.out_rd_we, bus1.out_is_load, bus1.out_is_store,
                            bus1.out_is_branch, bus1.out_is_jump, bus1.out_illegal}),
                exp_t'(exp_q1.pop_front()));
      end
    end
  end

  // ---------------- driver ----------------
  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send(input int d, input logic [31:0] inst, input logic [31:0] pc,
                      input exp_t e, input bit track, output int acc_cyc);
    int   n;
    logic rdy;
    n = 0;
    e.pc = pc;
    if (d == 0) begin
      bus0.in_valid = 1'b1; bus0.in_inst = inst; bus0.in_pc = pc;
    end else begin
      bus1.in_valid = 1'b1; bus1.in_inst = inst; bus1.in_pc = pc;
    end
    #1;
    rdy = (d == 0) ? bus0.in_ready : bus1.in_ready;
    while (!rdy && n < 20) begin
      @(negedge clk);
      #1;
      rdy = (d == 0) ? bus0.in_ready : bus1.in_ready;
      n++;
    end
    acc_cyc = cyc;
    if (!rdy) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL send_timeout: inst %h never accepted on dut%0d", inst, d);
      acc_cyc = -1;
    end else if (track) begin
      if (d == 0) exp_q0.push_back(e);
      else        exp_q1.push_back(e);
    end
    @(negedge clk);
    if (d == 0) bus0.in_valid = 1'b0;
    else        bus1.in_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  localparam logic [31:0] I_ADDI  = 32'hFFF08293;  // addi x5,x1,-1
  localparam logic [31:0] I_JAL   = 32'h001000EF;  // jal x1,+2048
  localparam logic [31:0] I_AUIPC = 32'h12345197;  // auipc x3,0x12345
  localparam logic [31:0] I_SW    = 32'h00512423;  // sw x5,8(x2)
  localparam logic [31:0] I_BEQ   = 32'hFE208EE3;  // beq x1,x2,-4
  localparam logic [31:0] I_SRAI  = 32'h40325213;  // srai x4,x4,3
  localparam logic [31:0] I_SLLX  = 32'h402091B3;  // sll with fn7=0100000
  localparam logic [31:0] I_MUL   = 32'h02C58533;  // mul x10,x11,x12
  localparam logic [31:0] I_LOW   = 32'hFFF08291;  // inst[1:0]=01
  localparam logic [31:0] I_LW    = 32'h00012303;  // lw x6,0(x2)
  localparam logic [31:0] I_ADD   = 32'h006303B3;  // add x7,x6,x6

  initial begin
    int a0, a1, a2;
    bus0.flush = 1'b0; bus0.in_valid = 1'b0; bus0.in_inst = '0; bus0.in_pc = '0; bus0.out_ready = 1'b1;
    bus1.flush = 1'b0; bus1.in_valid = 1'b0; bus1.in_inst = '0; bus1.in_pc = '0; bus1.out_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(bus0.out_valid), 64'd0);
    chk("rst_opcode",    64'(bus0.out_opcode), 64'd0);
    chk("rst_imm",       64'(bus0.out_imm), 64'd0);
    chk("rst_pc",        64'(bus0.out_pc), 64'd0);
    chk("rst_flags",     64'({bus0.out_rd_we, bus0.out_is_load, bus0.out_illegal}), 64'd0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready",  64'(bus0.in_ready), 64'd1);
    @(negedge clk);

    // back-to-back decode of the basic formats
    send(0, I_ADDI,  32'h1000, mk(7'h13, 5, 1, 0, 3'd0, 7'h00, 32'hFFFFFFFF, 0, 6'b100000), 1, a0);
    send(0, I_JAL,   32'h1004, mk(7'h6F, 1, 0, 0, 3'd0, 7'h00, 32'h00000800, 0, 6'b100010), 1, a1);
    send(0, I_AUIPC, 32'h1008, mk(7'h17, 3, 0, 0, 3'd0, 7'h00, 32'h12345000, 0, 6'b100000), 1, a2);
    chk("throughput_1", 64'(a1 - a0), 64'd1);
    chk("throughput_2", 64'(a2 - a1), 64'd1);
    send(0, I_SW,    32'h100C, mk(7'h23, 0, 2, 5, 3'd2, 7'h00, 32'h00000008, 0, 6'b001000), 1, a0);
    send(0, I_BEQ,   32'h1010, mk(7'h63, 0, 1, 2, 3'd0, 7'h00, 32'hFFFFFFFC, 0, 6'b000100), 1, a0);
    send(0, I_SRAI,  32'h1014, mk(7'h13, 4, 4, 0, 3'd5, 7'h20, 32'h00000403, 0, 6'b100000), 1, a0);

    // illegal encodings still flow through
    send(0, 32'h0,   32'h1018, mk(7'h00, 0, 0, 0, 3'd0, 7'h00, 32'h0, 0, 6'b000001), 1, a0);
    send(0, I_SLLX,  32'h101C, mk(7'h33, 3, 1, 2, 3'd1, 7'h20, 32'h0, 0, 6'b000001), 1, a0);
    send(0, I_MUL,   32'h1020, mk(7'h33, 10, 11, 12, 3'd0, 7'h01, 32'h0, 0, 6'b000001), 1, a0);
    send(0, I_LOW,   32'h1024, mk(7'h11, 0, 0, 0, 3'd0, 7'h00, 32'h0, 0, 6'b000001), 1, a0);

    // load-use: one bubble; independent follower: none
    send(0, I_LW,    32'h1028, mk(7'h03, 6, 2, 0, 3'd2, 7'h00, 32'h0, 0, 6'b110000), 1, a0);
    send(0, I_ADD,   32'h102C, mk(7'h33, 7, 6, 6, 3'd0, 7'h00, 32'h0, 0, 6'b100000), 1, a1);
    chk("load_use_gap", 64'(a1 - a0), 64'd2);
    send(0, I_LW,    32'h1030, mk(7'h03, 6, 2, 0, 3'd2, 7'h00, 32'h0, 0, 6'b110000), 1, a0);
    send(0, I_ADDI,  32'h1034, mk(7'h13, 5, 1, 0, 3'd0, 7'h00, 32'hFFFFFFFF, 0, 6'b100000), 1, a1);
    chk("no_dep_gap", 64'(a1 - a0), 64'd1);
    repeat (3) @(negedge clk);

    // stall with out_ready low, then flush together with an offered instruction
    bus0.out_ready = 1'b0;
    send(0, I_ADDI, 32'h2000, mk(7'h13, 5, 1, 0, 3'd0, 7'h00, 32'hFFFFFFFF, 0, 6'b100000), 1, a0);
    for (int i = 0; i < 3; i++) begin
      chk("stall_valid",    64'(bus0.out_valid), 64'd1);
      chk("stall_rd",       64'(bus0.out_rd), 64'd5);
      chk("stall_imm",      64'(bus0.out_imm), 64'hFFFFFFFF);
      chk("stall_pc",       64'(bus0.out_pc), 64'h2000);
      chk("stall_in_ready", 64'(bus0.in_ready), 64'd0);
      @(negedge clk);
    end
    bus0.flush = 1'b1;
    bus0.in_valid = 1'b1;
    bus0.in_inst = I_ADD;
    bus0.in_pc = 32'h2004;
    void'(exp_q0.pop_back());
    #1;
    chk("flush_in_ready", 64'(bus0.in_ready), 64'd0);
    @(negedge clk);
    bus0.flush = 1'b0;
    bus0.in_valid = 1'b0;
    #1;
    chk("flush_out_valid", 64'(bus0.out_valid), 64'd0);
    chk("flush_in_ready_after", 64'(bus0.in_ready), 64'd1);
    @(negedge clk);

    // reset while holding a valid instruction
    send(0, I_JAL, 32'h3000, mk(7'h6F, 1, 0, 0, 3'd0, 7'h00, 32'h800, 0, 6'b100010), 0, a0);
    chk("pre_rst_valid", 64'(bus0.out_valid), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid",  64'(bus0.out_valid), 64'd0);
    chk("mid_rst_opcode", 64'(bus0.out_opcode), 64'd0);
    chk("mid_rst_rd",     64'(bus0.out_rd), 64'd0);
    chk("mid_rst_imm",    64'(bus0.out_imm), 64'd0);
    chk("mid_rst_pc",     64'(bus0.out_pc), 64'd0);
    chk("mid_rst_flags",  64'({bus0.out_rd_we, bus0.out_is_jump}), 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(bus0.in_ready), 64'd1);
    bus0.out_ready = 1'b1;
    @(negedge clk);

    // M enabled, hazard stall disabled
    send(1, I_MUL, 32'h4000, mk(7'h33, 10, 11, 12, 3'd0, 7'h01, 32'h0, 0, 6'b100000), 1, a0);
    send(1, I_LW,  32'h4004, mk(7'h03, 6, 2, 0, 3'd2, 7'h00, 32'h0, 0, 6'b110000), 1, a0);
    send(1, I_ADD, 32'h4008, mk(7'h33, 7, 6, 6, 3'd0, 7'h00, 32'h0, 0, 6'b100000), 1, a1);
    chk("nohaz_gap", 64'(a1 - a0), 64'd1);
    repeat (4) @(negedge clk);

    chk("drain_q0", 64'(exp_q0.size()), 64'd0);
    chk("drain_q1", 64'(exp_q1.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered RV32I instruction-decode stage sitting between the fetch buffer and the execute stage. It extracts register indices, function fields and a sign-extended immediate, classifies and legality-checks the instruction, and holds the result in an ID/EX pipeline register with valid/ready flow control. It adds synchronous flush and an optional one-cycle load-use bubble, and supports an optional M-extension decode.

## Interface
Parameters:
- XLEN, 32, datapath width; `out_imm`/`out_pc` width, ≥32, immediates sign-extended to XLEN
- EN_M, 0, 1 = accept R-type fn7=0000001 (MUL/DIV group) as legal
- HAZARD_EN, 1, 1 = insert load-use bubble; 0 = never stall for hazards

Ports:
- Single clock `clk`; synchronous active-high reset `rst`.
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- flush  in  1  kill held instruction, block acceptance this cycle
- in_valid  in  1  fetch offers an instruction
- in_ready  out  1  stage accepts this cycle
- in_inst  in  32  instruction word
- in_pc  in  XLEN  instruction address
- out_valid  out  1  ID/EX register holds an instruction
- out_ready  in  1  execute consumes this cycle
- out_opcode  out  7  inst[6:0]
- out_rd, out_rs1, out_rs2  out  5 each  register indices, 0 when format lacks them
- out_fn3  out  3  funct3, 0 for U/J
- out_fn7  out  7  funct7 for R-type and shift-immediates, else 0
- out_imm  out  XLEN  sign-extended immediate (I/S/B/U/J), 0 for R-type
- out_pc  out  XLEN  registered in_pc
- out_rd_we  out  1  writes rd (rd≠0, legal, format has rd)
- out_is_load, out_is_store, out_is_branch, out_is_jump  out  1 each  class flags
- out_illegal  out  1  illegal encoding; instruction still passed for trap

## Operation
- Opcodes: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP-IMM 0010011, OP 0110011. Anything else illegal.
- Fields: U/J carry rd only; JALR/LOAD/OP-IMM carry rd, rs1, fn3; BRANCH/STORE carry rs1, rs2, fn3; OP carries all. LOAD does not report rs2.
- Illegal if any of: unknown opcode; JALR fn3≠000; BRANCH fn3 ∈ {010,011}; LOAD fn3 ∈ {011,110,111}; STORE fn3 > 010; OP-IMM shift (fn3 001/101) with fn7 ∉ {0000000, 0100000} (0100000 only with fn3 101); OP fn7=0100000 with fn3 ∉ {000,101}; OP fn7=0000001 with EN_M=0; OP any other fn7; inst[1:0]≠11.
- Illegal instruction: out_rd_we=0, class flags 0, fields still decoded per opcode (all 0 for unknown opcode).
- Hazard (HAZARD_EN=1): out_valid & out_is_load & out_rd≠0 & incoming reads out_rd (rs1 or rs2, per field rules).
- in_ready = (!out_valid | out_ready) & !hazard & !flush.
- Register update priority: rst > flush (out_valid←0) > accept (in_valid & in_ready: load decode, out_valid←1) > consume without accept (out_valid←0, bubble) > hold.

## Timing
- Latency 1 cycle: instruction accepted at edge N is visible on out_* after edge N.
- Full throughput, no bubbles absent hazards; back-to-back accept while out_ready=1.
- out_* stable while out_valid & !out_ready; in_ready combinational, no in_valid→in_ready path.
- Load-use: exactly one bubble cycle (out_valid=0) between load and dependent consumer, provided out_ready=1.
- Reset: out_valid=0, all out_* fields 0. Reset or flush mid-stall drops held instruction; next cycle in_ready=!flush.
- Simultaneous flush and in_valid: nothing accepted, out_valid=0 next cycle.

## Structure
- Package `rv_pkg`: opcode localparams, fn3/fn7 constants, `decoded_t` struct (all out_* fields except handshake).
- Sub-module `imm_gen` (combinational, inst + format → XLEN immediate); decode/legality comb logic plus register in `decode_stage`.

## Test plan
- ADDI x5,x1,-1 (0xFFF08293) accepted → next cycle out_rd=5, rs1=1, fn3=000, imm=0xFFFFFFFF, rd_we=1, illegal=0.
- JAL x1,+2048 (0x001000EF) → opcode 1101111, rd=1, imm=0x00000800, is_jump=1; AUIPC x3,0x12345 → imm=0x12345000.
- LW x6,0(x2) then ADD x7,x6,x6 with out_ready=1 → one bubble cycle, ADD output two cycles after LW; HAZARD_EN=0 → no bubble.
- Illegal: 0x00000000, SUB-style fn7 on fn3=001, MUL with EN_M=0 → illegal=1, rd_we=0; MUL with EN_M=1 → legal, fn7=0000001.
- out_ready held low 3 cycles with valid output → out_* unchanged, in_ready=0; flush asserted during stall → out_valid=0 next cycle.
- rst asserted while out_valid=1 → all outputs 0 next cycle, in_ready=1 after release.
